// File: rtl/ex_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// ex_hazard_ctrl
//
// Hazard and forwarding controller for a 5-stage pipeline. It tracks a 3-slot
// destination scoreboard (EX, MEM, WB) that moves in lockstep with the
// pipeline registers. From it, the block derives:
//   - the EX operand forwarding selects,
//   - the ID-stage write-back bypass,
//   - the PC / IF-ID write enables,
//   - the flush, bubble and hold strobes.
// Each cycle takes exactly one action. Highest priority first:
//   FREEZE (mem_busy) > FLUSH (ex_redirect) > STALL (hazard) > RUN.
//
// Build option: define EX_FORWARDING_EN for the forwarding build.
//   - With it, only load-use stalls (one bubble).
//   - Without it, the block is a full interlock: any dependence on an
//     in-flight writer stalls until the producer has left WB, and all
//     forwarding outputs are tied to 0.
//
// Ports:
//   clk, reset (async, active-high)
//   id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest,
//     id_reg_write, id_mem_read                        : ID instruction info
//   ex_redirect                                        : taken branch/jump in EX
//   mem_busy                                           : data memory not ready
//   pc_write, ifid_write, ifid_flush, idex_bubble,
//     pipe_hold                                        : pipeline control
//   control_a, control_b : EX operand select (00 reg, 01 MEM, 10 WB)
//   id_fwd_a, id_fwd_b   : ID/EX latch takes WB write data
//   ctrl_state           : previous action (00 RUN, 01 STALL, 10 FREEZE, 11 FLUSH)
//   stall_count          : saturating count of STALL + FREEZE cycles
// ----------------------------------------------------------------------------
module ex_hazard_ctrl #(
  parameter int WORD_SIZE = 16,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [1:0]       id_rs,
  input  logic [1:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [1:0]       id_dest,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_hold,
  output logic [1:0]       control_a,
  output logic [1:0]       control_b,
  output logic             id_fwd_a,
  output logic             id_fwd_b,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0] ACT_RUN    = 2'b00;
  localparam logic [1:0] ACT_STALL  = 2'b01;
  localparam logic [1:0] ACT_FREEZE = 2'b10;
  localparam logic [1:0] ACT_FLUSH  = 2'b11;

  // No datapath passes through this block; WORD_SIZE is informational only.
  if (WORD_SIZE > 0) begin : g_word_size_doc
  end

  typedef struct packed {
    logic       valid;
    logic [1:0] rs;
    logic [1:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic [1:0] dest;
    logic       reg_write;
    logic       mem_read;
  } slot_t;

  slot_t            ex_q, mem_q, wb_q;
  slot_t            ex_d, mem_d, wb_d;
  slot_t            id_slot;
  logic [1:0]       action;
  logic [1:0]       ctrl_state_q;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             hazard;
  logic             ex_wr, mem_wr, wb_wr;

  assign id_slot = '{valid: id_valid, rs: id_rs, rt: id_rt,
                     use_rs: id_use_rs, use_rt: id_use_rt, dest: id_dest,
                     reg_write: id_reg_write, mem_read: id_mem_read};

  assign ex_wr  = ex_q.valid  & ex_q.reg_write;
  assign mem_wr = mem_q.valid & mem_q.reg_write;
  assign wb_wr  = wb_q.valid  & wb_q.reg_write;

  // True when a valid ID instruction actually reads register r.
  function automatic logic id_reads(input logic [1:0] r, input logic vld,
                                    input logic urs, input logic [1:0] rs,
                                    input logic urt, input logic [1:0] rt);
    return vld & ((urs & (rs == r)) | (urt & (rt == r)));
  endfunction

`ifdef EX_FORWARDING_EN
  // Only a load in EX cannot be forwarded in time for the next instruction.
  assign hazard = ex_wr & ex_q.mem_read &
                  id_reads(ex_q.dest, id_valid, id_use_rs, id_rs, id_use_rt, id_rt);

  // MEM is the younger producer, so it wins over WB.
  always_comb begin
    control_a = 2'b00;
    control_b = 2'b00;
    if (ex_q.valid && ex_q.use_rs) begin
      if (mem_wr && (mem_q.dest == ex_q.rs))     control_a = 2'b01;
      else if (wb_wr && (wb_q.dest == ex_q.rs))  control_a = 2'b10;
    end
    if (ex_q.valid && ex_q.use_rt) begin
      if (mem_wr && (mem_q.dest == ex_q.rt))     control_b = 2'b01;
      else if (wb_wr && (wb_q.dest == ex_q.rt))  control_b = 2'b10;
    end
  end

  // The register file writes at the end of WB, so ID would read stale data.
  assign id_fwd_a = id_valid & id_use_rs & wb_wr & (wb_q.dest == id_rs);
  assign id_fwd_b = id_valid & id_use_rt & wb_wr & (wb_q.dest == id_rt);
`else
  // Full interlock: any in-flight writer of a used source blocks ID.
  assign hazard =
      (ex_wr  & id_reads(ex_q.dest,  id_valid, id_use_rs, id_rs, id_use_rt, id_rt)) |
      (mem_wr & id_reads(mem_q.dest, id_valid, id_use_rs, id_rs, id_use_rt, id_rt)) |
      (wb_wr  & id_reads(wb_q.dest,  id_valid, id_use_rs, id_rs, id_use_rt, id_rt));

  assign control_a = 2'b00;
  assign control_b = 2'b00;
  assign id_fwd_a  = 1'b0;
  assign id_fwd_b  = 1'b0;
`endif

  // Slot fields that a given build does not inspect.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{ex_q, mem_q, wb_q};

  always_comb begin
    if (mem_busy)         action = ACT_FREEZE;
    else if (ex_redirect) action = ACT_FLUSH;
    else if (hazard)      action = ACT_STALL;
    else                  action = ACT_RUN;
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    case (action)
      ACT_FREEZE: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        pipe_hold  = 1'b1;
      end
      ACT_FLUSH: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      ACT_STALL: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  // Scoreboard advance: hold on FREEZE, otherwise shift.
  // EX takes the ID instruction only on RUN.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (action != ACT_FREEZE) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = (action == ACT_RUN) ? id_slot : '0;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (((action == ACT_STALL) || (action == ACT_FREEZE)) && (stall_count_q != '1))
      stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      ctrl_state_q  <= ACT_RUN;
      stall_count_q <= '0;
    end else begin
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      ctrl_state_q  <= action;
      stall_count_q <= stall_count_d;
    end
  end

  assign ctrl_state  = ctrl_state_q;
  assign stall_count = stall_count_q;

endmodule
